trng_collector: RTL and testbench
=================================

# trng_collector

Consumer end of the ring-oscillator entropy path. Samples the registered raw bit stream from the combiner every clock and discards a warm-up window after enable. Runs a repetition-count health test on raw samples, applies von Neumann debiasing, and packs debiased bits into words. Words go to the downstream reader over a valid/ready handshake.

## Interface
- WORD_WIDTH, 32: bits per output word (≥2).
- WARMUP, 16: raw samples discarded after entering WARMUP; covers combiner pipeline depth and oscillator settling (≥1).
- REP_LIMIT, 32: consecutive identical raw samples that trip the health alarm (≥2).

Ports:
- clock  in  1  sole clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  collection enable; same signal that drives the oscillators.
- raw_bit  in  1  registered combiner output; one sample per clock.
- word_data  out  WORD_WIDTH  packed debiased word; first debiased bit in the MSB.
- word_valid  out  1  word_data holds an unread word.
- word_ready  in  1  reader accepts word_data.
- health_alarm  out  1  sticky repetition-test failure.
- clear_alarm  in  1  single-cycle pulse; clears the alarm.

## Operation
- Reset values: word_valid=0, word_data=0, health_alarm=0, FSM=IDLE, all counters, pair and packer state cleared.
- FSM states: IDLE, WARMUP, RUN, ALARM.
  - IDLE→WARMUP when enable=1.
  - WARMUP→RUN after WARMUP samples.
  - RUN→ALARM when the repetition count reaches REP_LIMIT.
  - ALARM→IDLE on clear_alarm=1.
  - IDLE, WARMUP or RUN→IDLE whenever enable=0; this takes priority over other transitions except entry to ALARM.
  - ALARM ignores enable.
- Health test, RUN only:
  - rep_cnt=1 on the first RUN sample.
  - On each later sample, +1 if raw_bit equals the previous sample, else reload 1.
  - rep_cnt==REP_LIMIT forces ALARM at that edge.
  - Counter width is clog2(REP_LIMIT+1).
- Von Neumann pairing, RUN only, over non-overlapping sample pairs:
  - State FIRST latches the sample.
  - State SECOND compares. Pair 10 emits 1, pair 01 emits 0, pairs 00 and 11 emit nothing.
  - The pair returns to FIRST on leaving RUN.
- Packer:
  - shift <= {shift[W-2:0], bit}, with a bit count.
  - When the W-th bit arrives and the output register is free, or is being drained at this edge, {shift[W-2:0], bit} loads word_data directly and the packer clears.
  - Otherwise the completed word is held in the packer (packer_full) and further debiased bits are dropped.
  - On the next handshake edge, the packer word moves to word_data, word_valid stays 1 and the packer clears.
- Handshake:
  - A transfer occurs on an edge with word_valid=1 and word_ready=1.
  - word_data is stable while word_valid=1 and word_ready=0.
  - word_valid falls after a transfer unless a replacement loads at the same edge.
- enable=0 behaviour:
  - The partial packer word and packer_full word are discarded; the pair state and rep_cnt are cleared.
  - The word already in word_data stays valid and readable.
- ALARM entry:
  - health_alarm=1.
  - word_valid=0, discarding any pending word.
  - Packer, pair state and rep_cnt are cleared.
  - No words are produced until clear_alarm, then a full WARMUP if enable=1.
- clear_alarm outside ALARM has no effect.
- Asynchronous reset mid-operation returns every output to its reset value immediately.

## Timing
- WARMUP: the sample on the first edge in WARMUP is discard 1. RUN starts on the edge after discard number WARMUP.
- Word latency: word_valid=1 in the cycle after the edge that sampled the second bit of the pair completing the word. Minimum is 2·W RUN samples per word.
- Alarm latency: health_alarm and word_valid=0 are visible in the cycle after the edge sampling the REP_LIMIT-th identical bit.
- Back-to-back words with word_ready held at 1 need no bubble.
- A word can complete on the same edge that the reader drains the output register. The new word loads, word_valid stays 1, and nothing is dropped.

## Test plan
Benches use W=8, WARMUP=4, REP_LIMIT=6.
- Enable, 4 warm-up cycles, then raw 1,0 ×8 with word_ready=1 → word_data=0xFF, word_valid high 1 cycle after the 16th RUN sample. Then 0,1 ×8 → 0x00 with no bubble.
- Pairs 1,0 / 1,1 / 0,1 / 0,0 repeated, giving raw 1,0,1,1,0,1,0,0 ×4 → word 0xAA (bits 1,0,…); equal pairs add no bits; no alarm.
- word_ready=0 while producing 3 words (A, B, C) → word_data=A held, B in packer, C's bits dropped. Raise word_ready → A then B transfer on consecutive edges; C never appears.
- Raw 1 for 6 RUN cycles with a valid word pending → health_alarm=1, word_valid=0 next cycle. Pulse clear_alarm → 4-cycle WARMUP, then 0xFF from 1,0 ×8.
- Drop enable after 5 debiased bits with one word pending → pending word still readable. Re-enable → WARMUP, next word is built from fresh bits only.
- Assert reset_n=0 mid-word and during ALARM → all outputs 0 immediately; FSM returns to IDLE.

Source files
------------

// File: rtl/trng_collector.sv
// trng_collector: warm-up discard, repetition-count health test, von Neumann
// debiasing and MSB-first word packing for the ring-oscillator entropy stream.
module trng_collector #(
  parameter int WORD_WIDTH = 32,
  parameter int WARMUP     = 16,
  parameter int REP_LIMIT  = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  raw_bit,
  output logic [WORD_WIDTH-1:0] word_data,
  output logic                  word_valid,
  input  logic                  word_ready,
  output logic                  health_alarm,
  input  logic                  clear_alarm
);

  localparam int WARM_W = $clog2(WARMUP + 1);
  localparam int REP_W  = $clog2(REP_LIMIT + 1);
  localparam int CNT_W  = $clog2(WORD_WIDTH);

  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP - 1);
  localparam logic [REP_W-1:0]  REP_MAX   = REP_W'(REP_LIMIT);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(WORD_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WARMUP,
    ST_RUN,
    ST_ALARM
  } state_t;

  state_t state, state_next;

  logic [WARM_W-1:0]     warm_cnt;
  logic [REP_W-1:0]      rep_cnt;
  logic [REP_W-1:0]      rep_next;
  logic                  prev_bit;
  logic                  pair_second;
  logic                  pair_first;
  logic [WORD_WIDTH-1:0] pack_shift;
  logic [CNT_W-1:0]      pack_cnt;
  logic                  packer_full;

  logic                  rep_trip;
  logic                  sampling;
  logic                  emit;
  logic                  transfer;
  logic                  out_free;
  logic                  load_full;
  logic                  load_new;
  logic [WORD_WIDTH-1:0] pack_word;

  // rep_cnt of zero marks the first RUN sample, which always starts a new run.
  always_comb begin
    rep_next  = REP_W'(1);
    if (rep_cnt != '0 && raw_bit == prev_bit) begin
      rep_next = rep_cnt + REP_W'(1);
    end
    rep_trip  = (state == ST_RUN) && (rep_next == REP_MAX);
    sampling  = (state == ST_RUN) && enable && !rep_trip;
    emit      = sampling && pair_second && (pair_first != raw_bit);
    transfer  = word_valid && word_ready;
    out_free  = !word_valid || word_ready;
    pack_word = {pack_shift[WORD_WIDTH-2:0], pair_first};
    load_full = sampling && packer_full && transfer;
    load_new  = emit && !packer_full && (pack_cnt == CNT_LAST) && out_free;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (enable) state_next = ST_WARMUP;
      ST_WARMUP: begin
        if (!enable) begin
          state_next = ST_IDLE;
        end else if (warm_cnt == WARM_LAST) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (rep_trip) begin
          state_next = ST_ALARM;
        end else if (!enable) begin
          state_next = ST_IDLE;
        end
      end
      ST_ALARM:  if (clear_alarm) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      warm_cnt     <= '0;
      rep_cnt      <= '0;
      prev_bit     <= 1'b0;
      pair_second  <= 1'b0;
      pair_first   <= 1'b0;
      pack_shift   <= '0;
      pack_cnt     <= '0;
      packer_full  <= 1'b0;
      word_data    <= '0;
      word_valid   <= 1'b0;
      health_alarm <= 1'b0;
    end else begin
      warm_cnt <= (state == ST_WARMUP && state_next == ST_WARMUP) ? warm_cnt + WARM_W'(1) : '0;

      if (rep_trip) begin
        health_alarm <= 1'b1;
      end else if (state == ST_ALARM && clear_alarm) begin
        health_alarm <= 1'b0;
      end

      if (sampling) begin
        prev_bit    <= raw_bit;
        rep_cnt     <= rep_next;
        pair_second <= !pair_second;
        if (!pair_second) pair_first <= raw_bit;
      end else begin
        rep_cnt     <= '0;
        pair_second <= 1'b0;
      end

      if (load_full) begin
        word_data <= pack_shift;
      end else if (load_new) begin
        word_data <= pack_word;
      end

      if (rep_trip) begin
        word_valid <= 1'b0;
      end else if (load_full || load_new) begin
        word_valid <= 1'b1;
      end else if (transfer) begin
        word_valid <= 1'b0;
      end

      // A completed word parks in the packer only when the output register is busy.
      if (!sampling || load_full) begin
        pack_shift  <= '0;
        pack_cnt    <= '0;
        packer_full <= 1'b0;
      end else if (emit && !packer_full) begin
        if (pack_cnt == CNT_LAST) begin
          pack_cnt    <= '0;
          pack_shift  <= load_new ? '0 : pack_word;
          packer_full <= !load_new;
        end else begin
          pack_shift <= pack_word;
          pack_cnt   <= pack_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_trng_collector.sv
// tb_trng_collector: directed stimulus for trng_collector checked every cycle
// against a history-based behavioural model, plus literal spot checks.
module tb_trng_collector;

  localparam int W         = 8;
  localparam int WARMUP    = 4;
  localparam int REP_LIMIT = 6;

  logic         clock;
  logic         reset_n;
  logic         enable;
  logic         raw_bit;
  logic [W-1:0] word_data;
  logic         word_valid;
  logic         word_ready;
  logic         health_alarm;
  logic         clear_alarm;

  int checks = 0;
  int errors = 0;

  trng_collector #(
    .WORD_WIDTH(W),
    .WARMUP    (WARMUP),
    .REP_LIMIT (REP_LIMIT)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .enable      (enable),
    .raw_bit     (raw_bit),
    .word_data   (word_data),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .health_alarm(health_alarm),
    .clear_alarm (clear_alarm)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model: 0 idle, 1 warm-up, 2 run, 3 alarm; health and pairing derive from sample history.
  int           m_mode;
  int           m_warm;
  bit           m_run[$];
  bit           m_bits[$];
  bit           m_held;
  logic [W-1:0] m_held_word;
  bit           m_valid;
  logic [W-1:0] m_word;
  bit           m_alarm;

  task automatic model_reset();
    m_mode = 0;
    m_warm = 0;
    m_run.delete();
    m_bits.delete();
    m_held = 0;
    m_held_word = '0;
    m_valid = 0;
    m_word = '0;
    m_alarm = 0;
  endtask

  task automatic model_clear_run();
    m_run.delete();
    m_bits.delete();
    m_held = 0;
  endtask

  task automatic model_step(input bit en, input bit raw, input bit rdy, input bit clr);
    bit           xfer;
    bit           out_free;
    int           run_len;
    logic [W-1:0] w;
    xfer     = m_valid && rdy;
    out_free = !m_valid || rdy;
    case (m_mode)
      0: begin
        if (xfer) m_valid = 0;
        if (en) begin
          m_mode = 1;
          m_warm = 0;
        end
      end
      1: begin
        if (xfer) m_valid = 0;
        if (!en) begin
          m_mode = 0;
        end else begin
          m_warm++;
          if (m_warm == WARMUP) begin
            m_mode = 2;
            m_run.delete();
          end
        end
      end
      2: begin
        m_run.push_back(raw);
        run_len = 0;
        for (int i = m_run.size() - 1; i >= 0; i--) begin
          if (m_run[i] != raw) break;
          run_len++;
        end
        if (run_len == REP_LIMIT) begin
          m_alarm = 1;
          m_valid = 0;
          m_mode  = 3;
          model_clear_run();
        end else if (!en) begin
          if (xfer) m_valid = 0;
          m_mode = 0;
          model_clear_run();
        end else if (m_held) begin
          if (xfer) begin
            m_word = m_held_word;
            m_held = 0;
          end
        end else begin
          if (xfer) m_valid = 0;
          if (m_run.size() % 2 == 0 && m_run[m_run.size() - 2] != raw) begin
            m_bits.push_back(m_run[m_run.size() - 2]);
            if (m_bits.size() == W) begin
              for (int i = 0; i < W; i++) w[W-1-i] = m_bits[i];
              m_bits.delete();
              if (out_free) begin
                m_word  = w;
                m_valid = 1;
              end else begin
                m_held      = 1;
                m_held_word = w;
              end
            end
          end
        end
      end
      default: begin
        if (clr) begin
          m_mode  = 0;
          m_alarm = 0;
        end
      end
    endcase
  endtask

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_output();
    check_eq("word_valid", {31'd0, word_valid}, {31'd0, m_valid});
    check_eq("health_alarm", {31'd0, health_alarm}, {31'd0, m_alarm});
    check_eq("word_data", {24'd0, word_data}, {24'd0, m_word});
  endtask

  task automatic apply_stimulus(input bit en, input bit raw, input bit rdy, input bit clr);
    enable      = en;
    raw_bit     = raw;
    word_ready  = rdy;
    clear_alarm = clr;
    model_step(en, raw, rdy, clr);
    @(posedge clock);
    #1;
    check_output();
  endtask

  task automatic do_warmup(input bit rdy);
    apply_stimulus(1, 0, rdy, 0);
    for (int i = 0; i < WARMUP; i++) apply_stimulus(1, i[0], rdy, 0);
  endtask

  // Each bit becomes a differing pair: 1 as samples 1,0 and 0 as samples 0,1.
  task automatic feed_bits(input logic [W-1:0] w, input int n, input bit rdy);
    for (int i = 0; i < n; i++) begin
      apply_stimulus(1, w[W-1-i], rdy, 0);
      apply_stimulus(1, !w[W-1-i], rdy, 0);
    end
  endtask

  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("async reset word_valid", {31'd0, word_valid}, 32'd0);
    check_eq("async reset word_data", {24'd0, word_data}, 32'd0);
    check_eq("async reset health_alarm", {31'd0, health_alarm}, 32'd0);
    model_reset();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    check_output();
  endtask

  initial begin
    reset_n     = 1'b0;
    enable      = 1'b0;
    raw_bit     = 1'b0;
    word_ready  = 1'b0;
    clear_alarm = 1'b0;
    model_reset();
    @(posedge clock);
    @(posedge clock);
    #1;
    check_eq("reset word_valid", {31'd0, word_valid}, 32'd0);
    check_eq("reset word_data", {24'd0, word_data}, 32'd0);
    check_eq("reset health_alarm", {31'd0, health_alarm}, 32'd0);
    reset_n = 1'b1;

    // clear_alarm while idle must do nothing
    apply_stimulus(0, 0, 0, 1);
    check_eq("clear outside alarm", {31'd0, health_alarm}, 32'd0);

    // 1,0 x8 then 0,1 x8 with the reader always ready
    do_warmup(1);
    feed_bits(8'hFF, 8, 1);
    check_eq("first word valid", {31'd0, word_valid}, 32'd1);
    check_eq("first word 0xFF", {24'd0, word_data}, 32'h0000_00FF);
    feed_bits(8'h00, 8, 1);
    check_eq("second word 0x00", {24'd0, word_data}, 32'h0000_0000);
    check_eq("second word valid", {31'd0, word_valid}, 32'd1);

    // Equal pairs contribute no bits
    for (int r = 0; r < 4; r++) begin
      apply_stimulus(1, 1, 1, 0); apply_stimulus(1, 0, 1, 0);
      apply_stimulus(1, 1, 1, 0); apply_stimulus(1, 1, 1, 0);
      apply_stimulus(1, 0, 1, 0); apply_stimulus(1, 1, 1, 0);
      apply_stimulus(1, 0, 1, 0); apply_stimulus(1, 0, 1, 0);
    end
    check_eq("mixed pairs word 0xAA", {24'd0, word_data}, 32'h0000_00AA);
    check_eq("mixed pairs no alarm", {31'd0, health_alarm}, 32'd0);

    // Backpressure: A held, B parked, C dropped
    apply_stimulus(0, 0, 1, 0);
    do_warmup(0);
    feed_bits(8'hF0, 8, 0);
    feed_bits(8'h0F, 8, 0);
    feed_bits(8'h55, 8, 0);
    check_eq("held word A", {24'd0, word_data}, 32'h0000_00F0);
    apply_stimulus(1, 1, 1, 0);
    check_eq("parked word B", {24'd0, word_data}, 32'h0000_000F);
    check_eq("parked word B valid", {31'd0, word_valid}, 32'd1);
    apply_stimulus(1, 1, 1, 0);
    check_eq("word C dropped", {31'd0, word_valid}, 32'd0);

    // Repetition alarm with a pending word, then recovery
    feed_bits(8'h3D, 8, 0);
    for (int i = 0; i < REP_LIMIT - 1; i++) apply_stimulus(1, 1, 0, 0);
    check_eq("one below limit no alarm", {31'd0, health_alarm}, 32'd0);
    check_eq("one below limit word pending", {31'd0, word_valid}, 32'd1);
    apply_stimulus(1, 1, 0, 0);
    check_eq("alarm raised", {31'd0, health_alarm}, 32'd1);
    check_eq("alarm drops word", {31'd0, word_valid}, 32'd0);
    apply_stimulus(1, 0, 1, 1);
    check_eq("alarm cleared", {31'd0, health_alarm}, 32'd0);
    do_warmup(1);
    feed_bits(8'hFF, 8, 1);
    check_eq("post alarm word 0xFF", {24'd0, word_data}, 32'h0000_00FF);

    // Enable drop with a pending word and a partial word
    feed_bits(8'hB0, 5, 0);
    apply_stimulus(0, 0, 0, 0);
    check_eq("pending survives disable", {24'd0, word_data}, 32'h0000_00FF);
    check_eq("pending valid after disable", {31'd0, word_valid}, 32'd1);
    apply_stimulus(0, 0, 1, 0);
    do_warmup(1);
    feed_bits(8'h5A, 8, 1);
    check_eq("fresh word 0x5A", {24'd0, word_data}, 32'h0000_005A);

    // Asynchronous reset mid-word and during alarm
    feed_bits(8'hE0, 3, 1);
    do_reset();
    do_warmup(0);
    for (int i = 0; i < REP_LIMIT; i++) apply_stimulus(1, 1, 0, 0);
    check_eq("alarm before reset", {31'd0, health_alarm}, 32'd1);
    do_reset();
    do_warmup(1);
    feed_bits(8'hC3, 8, 1);
    check_eq("word after reset 0xC3", {24'd0, word_data}, 32'h0000_00C3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
